// File: rtl/qenc_pkg.sv
// Shared types and helpers for the quadrature encoder generator.
// The QENC_INDEX_EN macro (used in quadrature_encoder_gen) enables the index output.
package qenc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } qenc_state_t;

  // Effective step period substituted when a period of zero is latched.
  localparam int unsigned QENC_DEFAULT_PERIOD = 1;

  // Quadrature phase of the low position bits to {a,b}; a rising count makes A lead B.
  function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
    case (phase)
      2'b00:   return 2'b00;
      2'b01:   return 2'b10;
      2'b10:   return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

endpackage

// File: rtl/qenc_step_timer.sv
// Step-rate timer: latches the period on load, replaces zero with the default
// period, and emits a one-cycle strobe every period cycles while running.
module qenc_step_timer
  import qenc_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             step_o
);

  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] last_cnt;

  assign last_cnt = period_q - DIV_W'(1);
  assign step_o   = run_i && (cnt_q == last_cnt);

  // Counter next state: cleared on load, wraps to zero on each step strobe.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = step_o ? '0 : (cnt_q + DIV_W'(1));
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Period latch; only meaningful while running, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_i) begin
      period_q <= (period_i == '0) ? DIV_W'(QENC_DEFAULT_PERIOD) : period_i;
    end
  end

endmodule

// File: rtl/quadrature_encoder_gen.sv
// Quadrature encoder waveform generator: walks position toward a commanded
// signed target one count per step period, driving registered A/B (and Z).
// Optional index output enabled by defining QENC_INDEX_EN.
module quadrature_encoder_gen
  import qenc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DIV_W    = 16,
  parameter int CPR_LOG2 = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] target,
  input  logic                    target_valid,
  output logic                    target_ready,
  input  logic        [DIV_W-1:0] step_period,
  output logic                    enc_a,
  output logic                    enc_b,
  output logic                    enc_z,
  output logic signed [WIDTH-1:0] position,
  output logic                    busy,
  output logic                    done
);

  localparam logic signed [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef QENC_INDEX_EN
  localparam bit INDEX_EN = 1'b1;
`else
  localparam bit INDEX_EN = 1'b0;
`endif

  qenc_state_t             state_q;
  logic signed [WIDTH-1:0] target_q;
  logic signed [WIDTH-1:0] position_q;
  logic signed [WIDTH-1:0] position_d;
  logic                    enc_a_q;
  logic                    enc_b_q;
  logic                    enc_z_q;
  logic                    enc_z_d;
  logic                    done_q;
  logic                    accept;
  logic                    moving;
  logic                    at_target;
  logic                    step;

  assign accept    = target_valid && (state_q == IDLE);
  assign moving    = (state_q == MOVE);
  assign at_target = (position_q == target_q);

  qenc_step_timer #(
    .DIV_W(DIV_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .run_i   (moving),
    .period_i(step_period),
    .step_o  (step)
  );

  // Next position: one count toward the target on each step strobe.
  always_comb begin
    position_d = position_q;
    if (moving && !at_target && step) begin
      position_d = (target_q > position_q) ? (position_q + ONE) : (position_q - ONE);
    end
  end

  assign enc_z_d = INDEX_EN && (position_d[CPR_LOG2-1:0] == '0);

  // Target latch; held data only, consulted while moving.
  always_ff @(posedge clk) begin
    if (accept) begin
      target_q <= target;
    end
  end

  // FSM with registered position, quadrature outputs and done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      position_q <= '0;
      enc_a_q    <= 1'b0;
      enc_b_q    <= 1'b0;
      enc_z_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q               <= 1'b0;
      position_q           <= position_d;
      {enc_a_q, enc_b_q}   <= phase_to_ab(position_d[1:0]);
      enc_z_q              <= enc_z_d;
      case (state_q)
        IDLE: begin
          if (target_valid) begin
            state_q <= MOVE;
          end
        end
        MOVE: begin
          // A zero-length move completes without stepping; otherwise finish
          // on the same edge that lands on the target.
          if (at_target || (step && (position_d == target_q))) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign target_ready = (state_q == IDLE);
  assign busy         = moving;
  assign done         = done_q;
  assign position     = position_q;
  assign enc_a        = enc_a_q;
  assign enc_b        = enc_b_q;
  assign enc_z        = enc_z_q;

endmodule

// File: tb/tb_quadrature_encoder_gen.sv
// Directed bench for quadrature_encoder_gen with an inline quadrature
// decoder model fed from enc_a/enc_b.
module tb_quadrature_encoder_gen;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] target = '0;
  logic               target_valid = 1'b0;
  logic               target_ready;
  logic        [15:0] step_period = '0;
  logic               enc_a;
  logic               enc_b;
  logic               enc_z;
  logic signed [15:0] position;
  logic               busy;
  logic               done;

  int tests = 0;
  int fails = 0;

`ifdef QENC_INDEX_EN
  localparam bit IDX = 1'b1;
`else
  localparam bit IDX = 1'b0;
`endif

  quadrature_encoder_gen #(
    .WIDTH   (16),
    .DIV_W   (16),
    .CPR_LOG2(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .target      (target),
    .target_valid(target_valid),
    .target_ready(target_ready),
    .step_period (step_period),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .enc_z       (enc_z),
    .position    (position),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Decoder model and event counters, sampled on the falling edge.
  int       dec_cnt  = 0;
  int       ab_edges = 0;
  int       bad_cnt  = 0;
  int       done_cnt = 0;
  logic [1:0] prev_ab = 2'b00;

  function automatic int ab_to_phase(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      dec_cnt = 0;
      prev_ab = {enc_a, enc_b};
    end else begin
      if ({enc_a, enc_b} != prev_ab) begin
        int d;
        ab_edges++;
        d = (ab_to_phase({enc_a, enc_b}) - ab_to_phase(prev_ab)) & 3;
        if (d == 1) dec_cnt++;
        else if (d == 3) dec_cnt--;
        else bad_cnt++;
        prev_ab = {enc_a, enc_b};
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [1:0] up_ab [5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
  logic [1:0] dn_ab [8] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};

  initial begin
    // Reset held three cycles with a target offered.
    rst = 1'b0;
    target = 16'sd7;
    step_period = 16'd1;
    target_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outputs", {target_ready, busy, done, enc_a, enc_b, enc_z}, 6'b100000);
      chk("rst_position", position, 0);
    end
    target_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("idle_ready", {target_ready, busy, done}, 3'b100);
    chk("idle_z", enc_z, IDX);

    // 0 -> +5 at period 4.
    target = 16'sd5;
    step_period = 16'd4;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    chk("up_accept", {target_ready, busy}, 2'b01);
    for (int k = 1; k <= 5; k++) begin
      repeat (3) tick();
      chk("up_hold", position, k - 1);
      tick();
      chk("up_ab", {enc_a, enc_b}, up_ab[k-1]);
      chk("up_pos", position, k);
      chk("up_z", enc_z, IDX && (k % 4 == 0));
      chk("up_done", done, (k == 5));
    end
    tick();
    chk("up_after", {done, busy, target_ready}, 3'b001);
    chk("up_done_cnt", done_cnt, 1);

    // 5 -> -3 at period 1, B leading A.
    target = -16'sd3;
    step_period = 16'd1;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("dn_pos", position, 5 - k);
      chk("dn_ab", {enc_a, enc_b}, dn_ab[k-1]);
    end
    chk("dn_done", {done, busy}, 2'b10);
    tick();
    chk("dn_decoder", dec_cnt, -3);
    chk("dn_edges", ab_edges, 13);

    // Zero-length move.
    target = -16'sd3;
    step_period = 16'd5;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    chk("zero_busy", {busy, done}, 2'b10);
    tick();
    chk("zero_done", {done, busy, target_ready}, 3'b101);
    chk("zero_edges", ab_edges, 13);

    // -3 -> 7 at period 3 with a competing target offered while busy.
    target = 16'sd7;
    step_period = 16'd3;
    target_valid = 1'b1;
    tick();
    target = 16'sd100;
    repeat (10) tick();
    chk("busy_ignore", {target_ready, busy}, 2'b01);
    chk("busy_pos10", position, 0);
    target_valid = 1'b0;
    repeat (5) tick();
    chk("busy_pos15", position, 2);
    repeat (15) tick();
    chk("busy_final", position, 7);
    chk("busy_done", {done, target_ready, busy}, 3'b110);
    // Back-to-back accept at the edge ending the done cycle.
    target = 16'sd8;
    step_period = 16'd2;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    chk("b2b_accept", {done, busy}, 2'b01);
    tick();
    chk("b2b_hold", position, 7);
    tick();
    chk("b2b_pos", position, 8);
    chk("b2b_done", done, 1);

    // Period 0 behaves like period 1.
    target = 16'sd11;
    step_period = 16'd0;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    tick();
    chk("p0_step1", position, 9);
    tick();
    chk("p0_step2", position, 10);
    tick();
    chk("p0_step3", position, 11);
    chk("p0_done", done, 1);
    tick();
    chk("done_total", done_cnt, 6);

    // Reset asserted at the third step of a move.
    target = 16'sd20;
    step_period = 16'd2;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    repeat (6) tick();
    chk("abort_pos", position, 14);
    rst = 1'b0;
    tick();
    chk("abort_outputs", {target_ready, busy, done, enc_a, enc_b, enc_z}, 6'b100000);
    chk("abort_position", position, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_no_done", done_cnt, 6);
    chk("abort_idle", {target_ready, busy, done}, 3'b100);

    // Index: 0 -> 9 at period 1.
    target = 16'sd9;
    step_period = 16'd1;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("idx_pos", position, k);
      chk("idx_z", enc_z, IDX && (k % 4 == 0));
    end
    chk("idx_done", done, 1);
    tick();
    chk("decoder_final", dec_cnt, 9);
    chk("illegal_transitions", bad_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
